// File: rtl/if_fetch_queue.sv
// if_fetch_queue -- instruction fetch unit with PC generation, an in-order
// request/response instruction-memory interface and a DEPTH-entry fetch queue
// that feeds decode through a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/_pc        flush queue and restart fetch at redirect_pc
//   imem_req_valid/_addr      fetch request to instruction memory
//   imem_req_ready            memory accepts the request
//   imem_rsp_valid/_data      in-order response, latency >= 1 cycle
//   id_valid/_instr/_pc       head of the fetch queue presented to decode
//   id_ready                  decode consumes the head entry
//   perf_stall_cnt            (FETCH_PERF_EN) cycles with id_valid && !id_ready
//   perf_discard_cnt          (FETCH_PERF_EN) stale responses dropped
//
// Optional feature macro: FETCH_PERF_EN adds the two saturating perf counters.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_discard_cnt,
`endif
    input  logic            id_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  ent_pc    [DEPTH];
    logic [ILEN-1:0]  ent_instr [DEPTH];
    logic [DEPTH-1:0] ent_full;
    logic [PW-1:0]    head, tail, fptr;   // fptr = oldest allocated-but-unfilled
    logic [CW-1:0]    alloc_cnt, pend_cnt, discard_cnt;
    logic [ILEN-1:0]  last_instr;
    logic [XLEN-1:0]  last_pc;

    logic req_fire, pop, rsp_drop, rsp_fill;
    logic [CW:0] outstanding;

    // Every request still in memory is either pending (will fill) or stale
    // (will be dropped); cap the total so the discard counter cannot overflow.
    assign outstanding    = {1'b0, pend_cnt} + {1'b0, discard_cnt};
    assign imem_req_valid = !rst && !redirect_valid && (alloc_cnt < CW'(DEPTH))
                            && (outstanding < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid = ent_full[head] && !redirect_valid;
    assign id_instr = id_valid ? ent_instr[head] : last_instr;
    assign id_pc    = id_valid ? ent_pc[head]    : last_pc;
    assign pop      = id_valid && id_ready;

    assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (discard_cnt == '0) && (pend_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ent_full    <= '0;
            head        <= '0;
            tail        <= '0;
            fptr        <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            discard_cnt <= '0;
            last_instr  <= '0;
            last_pc     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving
            // this same cycle retires one of them.
            pc_q        <= redirect_pc & ~XLEN'(3);
            ent_full    <= '0;
            head        <= '0;
            tail        <= '0;
            fptr        <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            discard_cnt <= discard_cnt + pend_cnt
                           - CW'(imem_rsp_valid && (outstanding != '0));
        end else begin
            if (req_fire) begin
                ent_pc[tail] <= pc_q;
                tail         <= tail + 1'b1;
                pc_q         <= pc_q + XLEN'(4);
            end
            if (rsp_fill) begin
                ent_instr[fptr] <= imem_rsp_data;
                ent_full[fptr]  <= 1'b1;
                fptr            <= fptr + 1'b1;
            end
            if (pop) begin
                ent_full[head] <= 1'b0;
                head           <= head + 1'b1;
                last_instr     <= ent_instr[head];
                last_pc        <= ent_pc[head];
            end
            alloc_cnt   <= alloc_cnt + CW'(req_fire) - CW'(pop);
            pend_cnt    <= pend_cnt + CW'(req_fire) - CW'(rsp_fill);
            discard_cnt <= discard_cnt - CW'(rsp_drop);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (id_valid && !id_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (rsp_drop && perf_discard_cnt != '1)
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

    // A response with nothing outstanding is a memory protocol error.
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && pend_cnt == '0 && discard_cnt == '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue. The reference model tracks the fetch
// stream as a queue of issued PCs (with a filled flag) and memory as a queue
// of in-flight requests tagged with the redirect epoch they were issued in.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_discard_cnt;
`endif

    if_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_discard_cnt(perf_discard_cnt),
`endif
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic filled; } ent_t;
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

    ent_t        q[$];
    req_t        mem[$];
    logic [31:0] m_pc, m_last_pc, m_last_instr;
    int          epoch, cyc, m_stall, m_drop, dut_pops;
    int          checks = 0, errors = 0;
    int          p_idr, p_rqr, p_rsp, redir_pm, lat_min, lat_max;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        id_ready = 1'b0; imem_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_discard", perf_discard_cnt, 32'd0);
`endif
        q.delete(); mem.delete();
        m_pc = RESET_PC; m_last_pc = '0; m_last_instr = '0;
        m_stall = 0; m_drop = 0;
        epoch++;
        @(posedge clk);
        cyc++;
    endtask

    task automatic step();
        logic ex_rv, ex_iv, fire, pop, rsp_go;
        req_t r;
        @(negedge clk);
        rst            = 1'b0;
        id_ready       = ($urandom_range(99) < p_idr);
        imem_req_ready = ($urandom_range(99) < p_rqr);
        redirect_valid = ($urandom_range(999) < redir_pm);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : $urandom;
        rsp_go         = (mem.size() > 0) && (mem[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rsp_go;
        imem_rsp_data  = rsp_go ? mem_word(mem[0].addr) : $urandom;
        #1;
        // Issue is allowed while the queue has room and memory holds fewer
        // than DEPTH requests in total (current plus stale).
        ex_rv = !redirect_valid && (q.size() < DEPTH) && (mem.size() < DEPTH);
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, ex_rv});
        if (ex_rv) chk("req_addr", imem_req_addr, m_pc);
        ex_iv = (q.size() > 0) && q[0].filled && !redirect_valid;
        chk("id_valid", {31'd0, id_valid}, {31'd0, ex_iv});
        if (ex_iv) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_instr", id_instr, mem_word(q[0].pc));
        end else begin
            chk("id_pc_hold", id_pc, m_last_pc);
            chk("id_instr_hold", id_instr, m_last_instr);
        end
        if (id_valid && id_ready) dut_pops++;

        fire = ex_rv && imem_req_ready;
        pop  = ex_iv && id_ready;
        if (ex_iv && !id_ready) m_stall++;
        if (rsp_go) begin
            r = mem.pop_front();
            if (r.epoch == epoch) begin
                for (int i = 0; i < q.size(); i++)
                    if (!q[i].filled) begin q[i].filled = 1'b1; break; end
            end else begin
                m_drop++;
            end
        end
        if (pop) begin
            m_last_pc    = q[0].pc;
            m_last_instr = mem_word(q[0].pc);
            void'(q.pop_front());
        end
        if (redirect_valid) begin
            q.delete();
            epoch++;
            m_pc = redirect_pc & ~32'd3;
        end else if (fire) begin
            q.push_back('{m_pc, 1'b0});
            mem.push_back('{m_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic phase(int n, int idr, int rqr, int rsp, int rpm, int lmin, int lmax);
        p_idr = idr; p_rqr = rqr; p_rsp = rsp; redir_pm = rpm;
        lat_min = lmin; lat_max = lmax;
        for (int i = 0; i < n; i++) step();
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'(m_stall));
        chk("perf_discard", perf_discard_cnt, 32'(m_drop));
`endif
    endtask

    initial begin
        epoch = 0; cyc = 0; dut_pops = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;
        do_reset();

        // Streaming with 1-cycle memory: one instruction per cycle from cycle 2.
        phase(20, 100, 100, 100, 0, 1, 1);
        chk("throughput_pops", 32'(dut_pops), 32'd18);
        // Decode stalled: queue fills to DEPTH, then drains in order.
        phase(10, 0, 100, 100, 0, 1, 1);
        phase(10, 100, 100, 100, 0, 1, 1);
        // Memory not ready: request held stable.
        phase(4, 100, 0, 100, 0, 1, 1);
        phase(10, 100, 100, 100, 0, 3, 3);
        // Long-latency memory with redirects.
        phase(300, 70, 70, 80, 40, 1, 4);
        // Reset in the middle of traffic.
        do_reset();
        phase(1500, 50, 50, 60, 50, 1, 6);
        phase(300, 90, 90, 90, 120, 1, 3);
        phase(100, 100, 100, 100, 0, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
